spi_word_assembler: RTL and testbench

Parametrised assembler between the SPI slave byte receiver and the raytracing controller. It collects received SPI bytes into words of configurable width and buffers complete words in a small FIFO. The controller drains the FIFO through a valid/ready handshake. Flow-control, overflow and frame-abort signalling let the host MCU pace command writes through the interrupt line instead of relying on fixed delays.

---
 rtl/spi_word_assembler_pkg.sv | 25 ++
 rtl/spi_word_assembler_sync_fifo.sv | 83 ++++++++
 rtl/spi_word_assembler.sv | 187 ++++++++++++++++++
 tb/tb_spi_word_assembler.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_word_assembler_pkg.sv
// Shared types and helpers for the SPI word assembler.
//
// Contents:
//   SPI_BYTE_W   width of one received SPI byte
//   cmd_word_t   64-bit command word consumed by the raytracing controller
//   level_width  bits needed to hold a FIFO occupancy of 0..depth
//   ptr_width    bits needed to address depth FIFO entries
`timescale 1ns/1ps

package spi_word_assembler_pkg;

   localparam int SPI_BYTE_W = 8;
   localparam int CMD_WORD_W = 64;

   typedef logic [CMD_WORD_W-1:0] cmd_word_t;

   function automatic int level_width(input int depth);
      return $clog2(depth + 1);
   endfunction

   function automatic int ptr_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/spi_word_assembler_sync_fifo.sv
// First-word-fall-through synchronous FIFO holding assembled words.
//
// Parameters: WIDTH (word width), DEPTH (entries, power of two, >= 2)
// Ports:
//   clk      in   system clock
//   rst_     in   synchronous active-low reset
//   push_i   in   write data_i this cycle (ignored when full unless a pop
//                 happens in the same cycle)
//   data_i   in   word to write
//   pop_i    in   consume head word (ignored when empty)
//   data_o   out  head word, zero while empty
//   full_o   out  DEPTH words stored
//   empty_o  out  no words stored
//   level_o  out  number of words stored
`timescale 1ns/1ps

module sync_fifo
   import spi_word_assembler_pkg::*;
#(
   parameter int WIDTH = 64,
   parameter int DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          rst_,
   input  logic                          push_i,
   input  logic [WIDTH-1:0]              data_i,
   input  logic                          pop_i,
   output logic [WIDTH-1:0]              data_o,
   output logic                          full_o,
   output logic                          empty_o,
   output logic [level_width(DEPTH)-1:0] level_o
);

   localparam int LW = level_width(DEPTH);
   localparam int PW = ptr_width(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]    count_q, count_d;
   logic             do_push, do_pop;

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == LW'(DEPTH));
   assign level_o = count_q;

   // A full FIFO still accepts a write when the head leaves in the same cycle.
   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);

   // Masked so the head reads zero after reset without clearing the storage.
   assign data_o = empty_o ? '0 : mem_q[rd_ptr_q];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= data_i;
   end

endmodule

// File: rtl/spi_word_assembler.sv
// Assembles SPI slave bytes into WORD_BYTES-byte words and buffers them in a
// FWFT FIFO drained by the raytracing controller over valid/ready.
//
// Parameters: WORD_BYTES, FIFO_DEPTH, MSB_FIRST, ALMOST_FULL, TIMEOUT_CYCLES
// Ports:
//   clk           in   system clock
//   rst_          in   synchronous active-low reset
//   i_byte_dv     in   i_byte valid strobe
//   i_byte        in   received byte
//   i_abort       in   chip-select released; drop the partial word
//   o_word_valid  out  FIFO head valid
//   i_word_ready  in   consumer takes the head word
//   o_word        out  FIFO head word
//   o_level       out  words stored
//   o_irq         out  registered level >= ALMOST_FULL (MCU busy pin)
//   o_overflow    out  sticky: a completed word was dropped
//   i_clr_ovf     in   clear o_overflow (a new drop in the same cycle wins)
//   o_timeout     out  one-cycle pulse: partial word discarded after idling
//
// Build option: define SPI_ASM_TIMEOUT_EN to build the partial-word idle
// timeout; otherwise o_timeout is tied low and TIMEOUT_CYCLES is unused.
`timescale 1ns/1ps

module spi_word_assembler
   import spi_word_assembler_pkg::*;
#(
   parameter int WORD_BYTES     = 8,
   parameter int FIFO_DEPTH     = 4,
   parameter bit MSB_FIRST      = 1'b1,
   parameter int ALMOST_FULL    = FIFO_DEPTH - 1,
   parameter int TIMEOUT_CYCLES = 100000
) (
   input  logic                               clk,
   input  logic                               rst_,
   input  logic                               i_byte_dv,
   input  logic [SPI_BYTE_W-1:0]              i_byte,
   input  logic                               i_abort,
   output logic                               o_word_valid,
   input  logic                               i_word_ready,
   output logic [WORD_BYTES*SPI_BYTE_W-1:0]   o_word,
   output logic [level_width(FIFO_DEPTH)-1:0] o_level,
   output logic                               o_irq,
   output logic                               o_overflow,
   input  logic                               i_clr_ovf,
   output logic                               o_timeout
);

   localparam int W  = WORD_BYTES * SPI_BYTE_W;
   localparam int LW = level_width(FIFO_DEPTH);
   localparam int CW = ptr_width(WORD_BYTES);
   localparam logic [CW-1:0] CNT_LAST = CW'(WORD_BYTES - 1);

   // The final byte of a word goes straight from i_byte into the FIFO, so the
   // shift register only needs to hold the first WORD_BYTES-1 bytes.
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [W-9:0]   shreg_q, shreg_d;
   logic [W-9:0]   shift_next;
   logic [W-1:0]   word_full;
   logic           ovf_q, ovf_d;
   logic           irq_q, irq_d;
   logic           tmo_q, tmo_d;
   logic           timeout_fire;

   logic           byte_take;
   logic           word_done;
   logic           drop;

   logic [W-1:0]   fifo_data;
   logic           fifo_full;
   logic           fifo_empty;
   logic [LW-1:0]  fifo_level;

   assign byte_take = i_byte_dv && !i_abort;
   assign word_done = byte_take && (cnt_q == CNT_LAST);
   assign drop      = word_done && fifo_full && !i_word_ready;

   generate
      if (MSB_FIRST) begin : g_msb
         assign word_full = {shreg_q, i_byte};
         if (WORD_BYTES == 2) begin : g_two
            assign shift_next = i_byte;
         end else begin : g_wide
            assign shift_next = {shreg_q[W-17:0], i_byte};
         end
      end else begin : g_lsb
         assign word_full = {i_byte, shreg_q};
         if (WORD_BYTES == 2) begin : g_two
            assign shift_next = i_byte;
         end else begin : g_wide
            assign shift_next = {i_byte, shreg_q[W-9:8]};
         end
      end
   endgenerate

`ifdef SPI_ASM_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] IDLE_RELOAD = TW'(TIMEOUT_CYCLES - 1);

   logic [TW-1:0] idle_q, idle_d;

   // Down-counter parked at reload while no word is in progress; reaching
   // zero with bytes pending means TIMEOUT_CYCLES idle cycles have passed.
   always_comb begin
      idle_d       = idle_q;
      timeout_fire = 1'b0;
      if (i_byte_dv || i_abort || (cnt_q == '0)) begin
         idle_d = IDLE_RELOAD;
      end else if (idle_q == '0) begin
         timeout_fire = 1'b1;
         idle_d       = IDLE_RELOAD;
      end else begin
         idle_d = idle_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_) idle_q <= IDLE_RELOAD;
      else       idle_q <= idle_d;
   end
`else
   assign timeout_fire = 1'b0;
`endif

   always_comb begin
      cnt_d   = cnt_q;
      shreg_d = shreg_q;
      if (i_abort || timeout_fire) begin
         cnt_d   = '0;
         shreg_d = '0;
      end else if (i_byte_dv) begin
         if (word_done) begin
            cnt_d   = '0;
            shreg_d = '0;
         end else begin
            cnt_d   = cnt_q + 1'b1;
            shreg_d = shift_next;
         end
      end
   end

   always_comb begin
      ovf_d = ovf_q;
      if (drop)           ovf_d = 1'b1;
      else if (i_clr_ovf) ovf_d = 1'b0;
      irq_d = (fifo_level >= LW'(ALMOST_FULL));
      tmo_d = timeout_fire;
   end

   always_ff @(posedge clk) begin
      if (!rst_) begin
         cnt_q   <= '0;
         shreg_q <= '0;
         ovf_q   <= 1'b0;
         irq_q   <= 1'b0;
         tmo_q   <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         shreg_q <= shreg_d;
         ovf_q   <= ovf_d;
         irq_q   <= irq_d;
         tmo_q   <= tmo_d;
      end
   end

   sync_fifo #(
      .WIDTH (W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_    (rst_),
      .push_i  (word_done),
      .data_i  (word_full),
      .pop_i   (i_word_ready),
      .data_o  (fifo_data),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .level_o (fifo_level)
   );

   assign o_word_valid = !fifo_empty;
   assign o_word       = fifo_data;
   assign o_level      = fifo_level;
   assign o_irq        = irq_q;
   assign o_overflow   = ovf_q;
   assign o_timeout    = tmo_q;

endmodule

// File: tb/tb_spi_word_assembler.sv
// Self-checking bench for spi_word_assembler: an MSB-first and an LSB-first
// instance share all inputs. Directed word table, hand-written corner
// sequences, then randomized traffic against a queue-based reference model.
`timescale 1ns/1ps

module tb_spi_word_assembler;
   import spi_word_assembler_pkg::*;

   localparam int WB    = 8;
   localparam int DEPTH = 4;
   localparam int AF    = 3;
`ifdef SPI_ASM_TIMEOUT_EN
   localparam int TMO = 16;
`else
   localparam int TMO = 100000;
`endif

   logic        clk, rst_;
   logic        i_byte_dv, i_abort, i_word_ready, i_clr_ovf;
   logic [7:0]  i_byte;

   logic        o_valid_m, o_irq_m, o_ovf_m, o_tmo_m;
   logic [63:0] o_word_m;
   logic [2:0]  o_level_m;
   logic        o_valid_l, o_irq_l, o_ovf_l, o_tmo_l;
   logic [63:0] o_word_l;
   logic [2:0]  o_level_l;

   int n_pass  = 0;
   int n_total = 0;

   spi_word_assembler #(
      .WORD_BYTES(WB), .FIFO_DEPTH(DEPTH), .MSB_FIRST(1'b1),
      .ALMOST_FULL(AF), .TIMEOUT_CYCLES(TMO)
   ) dut_m (
      .clk(clk), .rst_(rst_), .i_byte_dv(i_byte_dv), .i_byte(i_byte),
      .i_abort(i_abort), .o_word_valid(o_valid_m), .i_word_ready(i_word_ready),
      .o_word(o_word_m), .o_level(o_level_m), .o_irq(o_irq_m),
      .o_overflow(o_ovf_m), .i_clr_ovf(i_clr_ovf), .o_timeout(o_tmo_m)
   );

   spi_word_assembler #(
      .WORD_BYTES(WB), .FIFO_DEPTH(DEPTH), .MSB_FIRST(1'b0),
      .ALMOST_FULL(AF), .TIMEOUT_CYCLES(TMO)
   ) dut_l (
      .clk(clk), .rst_(rst_), .i_byte_dv(i_byte_dv), .i_byte(i_byte),
      .i_abort(i_abort), .o_word_valid(o_valid_l), .i_word_ready(i_word_ready),
      .o_word(o_word_l), .o_level(o_level_l), .o_irq(o_irq_l),
      .o_overflow(o_ovf_l), .i_clr_ovf(i_clr_ovf), .o_timeout(o_tmo_l)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [63:0] bytes_in;   // first byte sent = bits [63:56]
      logic [63:0] exp_msb;
      logic [63:0] exp_lsb;
   } vec_t;

   vec_t vecs [4];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic send_byte(input logic [7:0] b);
      i_byte_dv = 1'b1;
      i_byte    = b;
      step();
      i_byte_dv = 1'b0;
      i_byte    = 8'h00;
   endtask

   task automatic send_word(input logic [63:0] w);
      for (int k = 0; k < WB; k++) send_byte(w[63-8*k -: 8]);
   endtask

   task automatic pop_one();
      i_word_ready = 1'b1;
      step();
      i_word_ready = 1'b0;
   endtask

   task automatic do_reset();
      i_byte_dv = 0; i_byte = 0; i_abort = 0; i_word_ready = 0; i_clr_ovf = 0;
      rst_ = 1'b0;
      step();
      rst_ = 1'b1;
      step();
   endtask

   function automatic logic [63:0] build_word(input logic [7:0] bq[$], input bit msb);
      logic [63:0] w = '0;
      for (int i = 0; i < WB; i++) begin
         if (msb) w = (w << 8) | 64'(bq[i]);
         else     w = w | (64'(bq[i]) << (8 * i));
      end
      return w;
   endfunction

   initial begin
      logic [63:0] words [5];
      logic [63:0] qm[$], ql[$];
      logic [7:0]  bq[$];
      bit          m_ovf, m_irq, pop, complete, dropped;
      logic [63:0] wm, wl;
      int          idle_run, pulses, first_at;
      bit          dv, ab, rdy, clr;
      logic [7:0]  b;

      vecs[0] = '{64'h0102030405060708, 64'h0102030405060708, 64'h0807060504030201};
      vecs[1] = '{64'hA0A1A2A3A4A5A6A7, 64'hA0A1A2A3A4A5A6A7, 64'hA7A6A5A4A3A2A1A0};
      vecs[2] = '{64'hDEADBEEFCAFEF00D, 64'hDEADBEEFCAFEF00D, 64'h0DF0FECAEFBEADDE};
      vecs[3] = '{64'h00000000000000FF, 64'h00000000000000FF, 64'hFF00000000000000};

      rst_ = 1'b1;
      do_reset();

      // reset state
      check("rst_valid",   64'(o_valid_m), 64'd0);
      check("rst_word",    o_word_m,       64'd0);
      check("rst_level",   64'(o_level_m), 64'd0);
      check("rst_irq",     64'(o_irq_m),   64'd0);
      check("rst_ovf",     64'(o_ovf_m),   64'd0);
      check("rst_tmo",     64'(o_tmo_m),   64'd0);

      // directed word table
      for (int i = 0; i < 4; i++) begin
         for (int k = 0; k < WB - 1; k++) send_byte(vecs[i].bytes_in[63-8*k -: 8]);
         check("tbl_valid_early", 64'(o_valid_m), 64'd0);
         send_byte(vecs[i].bytes_in[7:0]);
         check("tbl_valid",  64'(o_valid_m), 64'd1);
         check("tbl_level",  64'(o_level_m), 64'd1);
         check("tbl_word_msb", o_word_m, vecs[i].exp_msb);
         check("tbl_word_lsb", o_word_l, vecs[i].exp_lsb);
         pop_one();
         check("tbl_empty", 64'(o_valid_m), 64'd0);
      end

      // overflow: five words with no consumer
      do_reset();
      for (int i = 0; i < 5; i++) words[i] = {8'h10 + 8'(i), 56'h11223344556677 + 56'(i)};
      for (int i = 0; i < 5; i++) begin
         send_word(words[i]);
         step(); step();
         if (i == 1) check("ovf_irq_lvl2", 64'(o_irq_m), 64'd0);
         if (i == 2) check("ovf_irq_lvl3", 64'(o_irq_m), 64'd1);
         if (i == 3) check("ovf_none_yet", 64'(o_ovf_m), 64'd0);
      end
      check("ovf_level", 64'(o_level_m), 64'd4);
      check("ovf_set",   64'(o_ovf_m),   64'd1);
      for (int i = 0; i < 4; i++) begin
         check("ovf_drain_word", o_word_m, words[i]);
         pop_one();
      end
      check("ovf_drained", 64'(o_valid_m), 64'd0);
      check("ovf_sticky",  64'(o_ovf_m),   64'd1);
      i_clr_ovf = 1'b1; step(); i_clr_ovf = 1'b0;
      check("ovf_cleared", 64'(o_ovf_m), 64'd0);

      // full FIFO with simultaneous pop and push
      do_reset();
      for (int i = 0; i < 4; i++) send_word(words[i]);
      for (int k = 0; k < WB - 1; k++) send_byte(words[4][63-8*k -: 8]);
      i_word_ready = 1'b1;
      send_byte(words[4][7:0]);
      i_word_ready = 1'b0;
      check("simul_level", 64'(o_level_m), 64'd4);
      check("simul_ovf",   64'(o_ovf_m),   64'd0);
      for (int i = 1; i < 5; i++) begin
         check("simul_drain_word", o_word_m, words[i]);
         pop_one();
      end

      // abort after a partial word
      do_reset();
      send_byte(8'h55); send_byte(8'h66); send_byte(8'h77);
      i_abort = 1'b1; step(); i_abort = 1'b0;
      send_word(64'hA0A1A2A3A4A5A6A7);
      check("abort_word",  o_word_m,       64'hA0A1A2A3A4A5A6A7);
      check("abort_level", 64'(o_level_m), 64'd1);
      pop_one();

      // abort coincident with a byte: that byte must not appear
      send_byte(8'hB0); send_byte(8'hB1); send_byte(8'hB2);
      i_abort = 1'b1; i_byte_dv = 1'b1; i_byte = 8'hEE; step();
      i_abort = 1'b0; i_byte_dv = 1'b0;
      send_word(64'hC0C1C2C3C4C5C6C7);
      check("abort_dv_word",  o_word_m,       64'hC0C1C2C3C4C5C6C7);
      check("abort_dv_level", 64'(o_level_m), 64'd1);
      pop_one();

      // reset mid-word with a full FIFO, irq and overflow set
      do_reset();
      for (int i = 0; i < 5; i++) send_word(words[i]);
      step();
      send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
      rst_ = 1'b0; i_byte_dv = 1'b1; i_byte = 8'h04; step();
      i_byte_dv = 1'b0;
      check("rstmid_valid", 64'(o_valid_m), 64'd0);
      check("rstmid_word",  o_word_m,       64'd0);
      check("rstmid_level", 64'(o_level_m), 64'd0);
      check("rstmid_irq",   64'(o_irq_m),   64'd0);
      check("rstmid_ovf",   64'(o_ovf_m),   64'd0);
      rst_ = 1'b1; step();
      send_word(64'h8899AABBCCDDEEFF);
      check("rstmid_clean_word", o_word_m, 64'h8899AABBCCDDEEFF);
      check("rstmid_clean_lvl",  64'(o_level_m), 64'd1);

      // partial-word idle timeout
      do_reset();
      send_byte(8'h11); send_byte(8'h22);
      pulses = 0; first_at = 0;
      for (int t = 1; t <= 24; t++) begin
         step();
         if (o_tmo_m) begin
            pulses++;
            if (first_at == 0) first_at = t;
         end
      end
`ifdef SPI_ASM_TIMEOUT_EN
      check("tmo_pulses", 64'(pulses), 64'd1);
      check("tmo_at",     64'((first_at >= 16) && (first_at <= 17)), 64'd1);
      send_word(64'h0F1E2D3C4B5A6978);
      check("tmo_clean_word", o_word_m, 64'h0F1E2D3C4B5A6978);
      check("tmo_clean_lvl",  64'(o_level_m), 64'd1);
`else
      check("tmo_tied_low", 64'(pulses), 64'd0);
      i_abort = 1'b1; step(); i_abort = 1'b0;
`endif

      // randomized traffic against the queue model
      do_reset();
      qm.delete(); ql.delete(); bq.delete();
      m_ovf = 0; m_irq = 0; idle_run = 0;
      for (int cyc = 0; cyc < 2000; cyc++) begin
         dv  = ($urandom_range(0, 9) < 7) || (idle_run >= 8);
         b   = 8'($urandom);
         ab  = ($urandom_range(0, 59) == 0);
         rdy = (cyc < 700) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 9) < 6);
         clr = ($urandom_range(0, 29) == 0);
         idle_run = dv ? 0 : idle_run + 1;

         pop      = rdy && (qm.size() > 0);
         complete = 0;
         wm = '0; wl = '0;
         if (ab) bq.delete();
         else if (dv) begin
            bq.push_back(b);
            if (bq.size() == WB) begin
               complete = 1;
               wm = build_word(bq, 1'b1);
               wl = build_word(bq, 1'b0);
               bq.delete();
            end
         end
         dropped = complete && (qm.size() == DEPTH) && !pop;
         if (dropped)  m_ovf = 1;
         else if (clr) m_ovf = 0;
         m_irq = (qm.size() >= AF);
         if (pop) begin void'(qm.pop_front()); void'(ql.pop_front()); end
         if (complete && !dropped) begin qm.push_back(wm); ql.push_back(wl); end

         i_byte_dv = dv; i_byte = b; i_abort = ab; i_word_ready = rdy; i_clr_ovf = clr;
         step();

         check("rnd_valid",    64'(o_valid_m), 64'(qm.size() > 0));
         check("rnd_level",    64'(o_level_m), 64'(qm.size()));
         check("rnd_word_msb", o_word_m, (qm.size() > 0) ? qm[0] : 64'd0);
         check("rnd_word_lsb", o_word_l, (ql.size() > 0) ? ql[0] : 64'd0);
         check("rnd_irq",      64'(o_irq_m), 64'(m_irq));
         check("rnd_ovf",      64'(o_ovf_m), 64'(m_ovf));
         check("rnd_tmo",      64'(o_tmo_m), 64'd0);
      end
      i_byte_dv = 0; i_abort = 0; i_word_ready = 0; i_clr_ovf = 0;

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
